// File: rtl/bt_pipe_writer.sv
// rtl/bt_pipe_writer.sv - block-throttled pipe-in initiator with LFSR/counter data source
module bt_pipe_writer #(
    parameter int BLOCK_WORDS = 256,
    parameter int GAP_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] num_blocks,
    input  logic        mode,
    input  logic        ep_ready,
    output logic        ep_blockstrobe,
    output logic        ep_write,
    output logic [15:0] ep_dataout,
    output logic        busy,
    output logic        done,
    output logic [15:0] blocks_sent
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_READY,
        STROBE,
        GAP,
        WRITE,
        DONE
    } state_t;

    localparam logic [31:0] LFSR_SEED = 32'h5EED_0001;
    localparam logic [15:0] WORD_LAST = 16'(BLOCK_WORDS - 1);
    localparam logic [15:0] GAP_LAST  = 16'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam bit          HAS_GAP   = (GAP_CYCLES > 0);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] word_cnt;
    logic [15:0] gap_cnt;
    logic [15:0] blocks_lat;
    logic [15:0] sent_inc;
    logic        mode_lat;
    logic [31:0] gen;
    logic [31:0] gen_nxt;
    logic        start_ok;
    logic        accept;
    logic        last_word;

    // Datapath helpers: start qualification, end-of-block detect, next generator value
    always_comb begin
        start_ok  = (state == IDLE) && start && !abort;
        accept    = start_ok && (num_blocks != 16'd0);
        last_word = (state == WRITE) && (word_cnt == WORD_LAST);
        sent_inc  = blocks_sent + 16'd1;
        if (mode_lat) begin
            gen_nxt = {gen[31:16], gen[15:0] + 16'd1};
        end else begin
            gen_nxt = {gen[30:0], gen[31] ^ gen[21] ^ gen[1] ^ gen[0]};
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_blocks != 16'd0) ? WAIT_READY : DONE;
                end
            end
            WAIT_READY: begin
                if (ep_ready) begin
                    state_nxt = STROBE;
                end
            end
            STROBE: begin
                state_nxt = HAS_GAP ? GAP : WRITE;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (last_word) begin
                    state_nxt = (sent_inc == blocks_lat) ? DONE : WAIT_READY;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Phase counters: words within the current block and idle cycles after the strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt <= 16'd0;
            gap_cnt  <= 16'd0;
        end else begin
            word_cnt <= (state == WRITE) ? word_cnt + 16'd1 : 16'd0;
            gap_cnt  <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;
        end
    end

    // Registered outputs decoded from the upcoming state so they align with it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ep_blockstrobe <= 1'b0;
            ep_write       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            ep_blockstrobe <= (state_nxt == STROBE);
            ep_write       <= (state_nxt == WRITE);
            busy           <= (state_nxt == WAIT_READY) || (state_nxt == STROBE) ||
                              (state_nxt == GAP) || (state_nxt == WRITE);
            done           <= (state_nxt == DONE);
        end
    end

    // Transfer parameters, completed-block count and the continuous data generator
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blocks_lat  <= 16'd0;
            mode_lat    <= 1'b0;
            blocks_sent <= 16'd0;
            gen         <= 32'd0;
            ep_dataout  <= 16'd0;
        end else begin
            if (start_ok) begin
                blocks_sent <= 16'd0;
            end else if (last_word && !abort) begin
                blocks_sent <= sent_inc;
            end
            if (accept) begin
                blocks_lat <= num_blocks;
                mode_lat   <= mode;
                gen        <= mode ? 32'd1 : LFSR_SEED;
            end else if (state_nxt == WRITE) begin
                ep_dataout <= gen[15:0];
                gen        <= gen_nxt;
            end
        end
    end

endmodule

// File: tb/tb_bt_pipe_writer.sv
// tb/tb_bt_pipe_writer.sv - randomized self-checking bench for bt_pipe_writer
module tb_bt_pipe_writer;

    localparam int BW  = 4;
    localparam int GAP = 2;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [15:0] num_blocks;
    logic        mode;
    logic        ep_ready;
    logic        ep_blockstrobe;
    logic        ep_write;
    logic [15:0] ep_dataout;
    logic        busy;
    logic        done;
    logic [15:0] blocks_sent;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bt_pipe_writer #(
        .BLOCK_WORDS(BW),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .num_blocks    (num_blocks),
        .mode          (mode),
        .ep_ready      (ep_ready),
        .ep_blockstrobe(ep_blockstrobe),
        .ep_write      (ep_write),
        .ep_dataout    (ep_dataout),
        .busy          (busy),
        .done          (done),
        .blocks_sent   (blocks_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transfer observed cycle by cycle against a timeline built from the protocol rules
    task automatic run_xfer(input int nb, input bit md, input int rmode, input int abort_at,
                            input bit noise);
        int          k;
        int          strobe_c;
        int          first_w;
        int          last_w;
        int          nstrobe;
        int          blocks_exp;
        int          words;
        int          blk_words;
        int          low_cnt;
        bit          wait_prev;
        bit          wait_now;
        bit          ready_prev;
        bit          exp_strobe;
        bit          exp_write;
        bit          exp_done;
        bit          finished;
        logic [31:0] ref_lfsr;
        logic [15:0] ref_cnt;
        logic [15:0] exp_data;

        ref_lfsr   = 32'h5EED_0001;
        ref_cnt    = 16'h0001;
        strobe_c   = -1000;
        nstrobe    = 0;
        blocks_exp = 0;
        words      = 0;
        low_cnt    = 0;
        wait_prev  = 1'b0;
        ready_prev = 1'b0;
        finished   = 1'b0;

        num_blocks = 16'(nb);
        mode       = md;
        abort      = 1'b0;
        ep_ready   = 1'b1;
        start      = 1'b1;
        k          = cyc;
        tick();
        start      = 1'b0;
        num_blocks = 16'($urandom_range(1, 9));
        mode       = 1'($urandom_range(0, 1));

        for (int n = 0; n < 3000 && !finished; n++) begin
            exp_strobe = wait_prev && ready_prev;
            if (exp_strobe) begin
                nstrobe++;
                strobe_c = cyc;
            end
            first_w   = strobe_c + GAP + 1;
            last_w    = strobe_c + GAP + BW;
            exp_write = (cyc >= first_w) && (cyc <= last_w);
            exp_done  = (nstrobe == nb) && (cyc == last_w + 1);
            blk_words = cyc - first_w;

            check("strobe", ep_blockstrobe, exp_strobe);
            check("write", ep_write, exp_write);
            check("done", done, exp_done);
            check("busy", busy, !exp_done);
            check("blocks_sent", blocks_sent, blocks_exp);
            if (exp_write) begin
                exp_data = md ? ref_cnt : ref_lfsr[15:0];
                check("data", ep_dataout, exp_data);
                ref_cnt  = ref_cnt + 16'd1;
                ref_lfsr = {ref_lfsr[30:0], ^(ref_lfsr & 32'h8020_0003)};
                words++;
                if (cyc == last_w) begin
                    blocks_exp++;
                end
            end
            wait_now = (cyc == k + 1) || (wait_prev && !exp_strobe) ||
                       ((cyc == last_w + 1) && (nstrobe < nb));

            if (abort_at > 0 && exp_write && words == abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check("abort_write", ep_write, 1'b0);
                check("abort_strobe", ep_blockstrobe, 1'b0);
                check("abort_busy", busy, 1'b0);
                check("abort_done", done, 1'b0);
                check("abort_sent", blocks_sent, blocks_exp);
                abort      = 1'b1;
                start      = 1'b1;
                num_blocks = 16'd2;
                tick();
                abort = 1'b0;
                start = 1'b0;
                check("abort_start_busy", busy, 1'b0);
                check("abort_start_done", done, 1'b0);
                tick();
                check("abort_idle_busy", busy, 1'b0);
                check("abort_idle_strobe", ep_blockstrobe, 1'b0);
                finished = 1'b1;
            end else if (exp_done) begin
                start      = 1'b1;
                num_blocks = 16'd3;
                mode       = !md;
                tick();
                start = 1'b0;
                check("post_done_busy", busy, 1'b0);
                check("post_done_done", done, 1'b0);
                check("post_done_sent", blocks_sent, nb);
                tick();
                check("idle_busy", busy, 1'b0);
                check("idle_strobe", ep_blockstrobe, 1'b0);
                finished = 1'b1;
            end else begin
                case (rmode)
                    0: ep_ready = 1'b1;
                    1: ep_ready = ($urandom_range(0, 2) != 0);
                    default: begin
                        if (blocks_exp == 1 && low_cnt < 10) begin
                            ep_ready = 1'b0;
                            low_cnt++;
                        end else if (exp_write && blk_words >= 1 && blk_words <= 2) begin
                            ep_ready = 1'b0;
                        end else begin
                            ep_ready = 1'b1;
                        end
                    end
                endcase
                if (noise && $urandom_range(0, 3) == 0) begin
                    start      = 1'b1;
                    num_blocks = 16'($urandom_range(0, 9));
                    mode       = 1'($urandom_range(0, 1));
                end else begin
                    start = 1'b0;
                end
                ready_prev = ep_ready;
                wait_prev  = wait_now;
                tick();
            end
        end
        start = 1'b0;
        check("xfer_finished", finished, 1'b1);
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        num_blocks = 16'd0;
        mode       = 1'b0;
        ep_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_strobe", ep_blockstrobe, 1'b0);
        check("rst_write", ep_write, 1'b0);
        check("rst_data", ep_dataout, 16'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sent", blocks_sent, 16'd0);
        reset_n = 1'b1;
        tick();
        check("idle_after_rst", busy, 1'b0);

        // Counter mode, two blocks, ready always high
        run_xfer(2, 1'b1, 0, 0, 1'b0);
        // LFSR mode, one block
        run_xfer(1, 1'b0, 0, 0, 1'b0);
        // Ready withheld before block 2 and dropped mid-block
        run_xfer(2, 1'b1, 2, 0, 1'b0);
        // Randomized transfers with random ready and spurious start pulses
        for (int t = 0; t < 6; t++) begin
            run_xfer($urandom_range(1, 3), 1'($urandom_range(0, 1)), 1, 0, 1'b1);
        end

        // Zero-block start completes immediately without activity
        num_blocks = 16'd0;
        mode       = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check("zero_done", done, 1'b1);
        check("zero_busy", busy, 1'b0);
        check("zero_strobe", ep_blockstrobe, 1'b0);
        check("zero_write", ep_write, 1'b0);
        tick();
        check("zero_done_clear", done, 1'b0);
        check("zero_busy_after", busy, 1'b0);

        // Abort on the third write, then restart from the first counter word
        run_xfer(2, 1'b1, 0, 3, 1'b0);
        run_xfer(1, 1'b1, 0, 0, 1'b0);

        // Reset mid-burst clears outputs without waiting for a clock edge
        num_blocks = 16'd1;
        mode       = 1'b1;
        ep_ready   = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("pre_rst_write", ep_write, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_write", ep_write, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_data", ep_dataout, 16'h0000);
        check("arst_strobe", ep_blockstrobe, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_busy", busy, 1'b0);
            check("post_rst_write", ep_write, 1'b0);
            check("post_rst_strobe", ep_blockstrobe, 1'b0);
            check("post_rst_done", done, 1'b0);
        end
        run_xfer(1, 1'b0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
